// File: rtl/jt89_pkg.sv
// Shared types, constants and byte encoders for the jt89 write sequencer.
// Entry layout: {ch[12:11], vol[10], data[9:0]}.
package jt89_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_LAT,
        ST_WAIT_LAT,
        ST_WR_DAT,
        ST_WAIT_DAT,
        ST_MUTE
    } state_e;

    localparam int         ENTRY_W        = 13;
    localparam int         LATCH_BIT      = 7;
    localparam logic [7:0] MUTE_BYTE      = 8'h9F;
    localparam logic [7:0] MUTE_CH_STRIDE = 8'h20;

    function automatic logic is_tone(input logic [ENTRY_W-1:0] e);
        return !e[10] && (e[12:11] != 2'd3);
    endfunction

    // Noise control only has three meaningful bits; bit 3 must stay clear.
    function automatic logic [7:0] latch_byte(input logic [ENTRY_W-1:0] e);
        logic [7:0] b;
        b            = 8'h00;
        b[LATCH_BIT] = 1'b1;
        b[6:5]       = e[12:11];
        b[4]         = e[10];
        b[3:0]       = e[3:0];
        if (e[12:11] == 2'd3 && !e[10]) begin
            b[3] = 1'b0;
        end
        return b;
    endfunction

    function automatic logic [7:0] data_byte(input logic [ENTRY_W-1:0] e);
        return {2'b00, e[9:4]};
    endfunction

    function automatic logic [7:0] mute_byte(input logic [1:0] idx);
        return MUTE_BYTE + MUTE_CH_STRIDE * {6'b000000, idx};
    endfunction

endpackage

// File: rtl/jt89_wrseq_fifo.sv
// Request FIFO for the jt89 write sequencer; flush empties it in one cycle.
module jt89_wrseq_fifo
    import jt89_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] wdata,
    output logic [ENTRY_W-1:0] rdata,
    output logic               full,
    output logic               empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        wr_q, wr_d;
    logic [AW:0]        rd_q, rd_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty   = (wr_q == rd_q);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + (AW+1)'(1);
            if (do_pop)  rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/jt89_wrseq.sv
// Serializes queued tone/volume/noise requests into SN76489 latch/data writes
// for jt89, with a minimum wr_n-high spacing and a flush-and-silence mute.
module jt89_wrseq
    import jt89_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_ch,
    input  logic       req_vol,
    input  logic [9:0] req_data,
    input  logic       mute,
    output logic       busy,
    output logic       wr_n,
    output logic [7:0] din
);
    localparam int               CNT_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ENTRY_W-1:0] cur_q, cur_d;
    logic               mute_pend_q, mute_pend_d;
    logic [2:0]         mute_idx_q, mute_idx_d;
    logic               wr_n_q, wr_n_d;
    logic [7:0]         din_q, din_d;
    logic               dispatch;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;

    // valid/ready: a request transfers on any clk edge where both are high;
    // a same-cycle mute pulse discards it.
    assign req_ready = ~fifo_full & ~mute_pend_q;
    assign fifo_push = req_valid & req_ready & ~mute;
    assign busy      = ~fifo_empty | (state_q != ST_IDLE) | mute_pend_q;
    assign wr_n      = wr_n_q;
    assign din       = din_q;

    jt89_wrseq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (mute),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({req_ch, req_vol, req_data}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_d       = cur_q;
        mute_pend_d = mute_pend_q;
        mute_idx_d  = mute_idx_q;
        wr_n_d      = wr_n_q;
        din_d       = din_q;
        dispatch    = 1'b0;
        fifo_pop    = 1'b0;

        if (clk_en) begin
            case (state_q)
                ST_IDLE: dispatch = 1'b1;
                ST_WR_LAT: begin
                    wr_n_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT_LAT;
                end
                ST_WAIT_LAT: begin
                    if (cnt_q == CNT_LAST) begin
                        if (is_tone(cur_q)) begin
                            din_d   = data_byte(cur_q);
                            wr_n_d  = 1'b0;
                            state_d = ST_WR_DAT;
                        end else begin
                            dispatch = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WR_DAT, ST_MUTE: begin
                    wr_n_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT_DAT;
                end
                ST_WAIT_DAT: begin
                    if (cnt_q == CNT_LAST) dispatch = 1'b1;
                    else                   cnt_d = cnt_q + CNT_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Gap end chains straight into the next write so back-to-back
        // requests keep the GAP+1 tick cadence.
        if (dispatch) begin
            state_d = ST_IDLE;
            if (mute_pend_q && !mute_idx_q[2]) begin
                din_d      = mute_byte(mute_idx_q[1:0]);
                wr_n_d     = 1'b0;
                mute_idx_d = mute_idx_q + 3'd1;
                state_d    = ST_MUTE;
            end else if (mute_pend_q) begin
                mute_pend_d = 1'b0;
            end else if (!fifo_empty) begin
                fifo_pop = 1'b1;
                cur_d    = fifo_head;
                din_d    = latch_byte(fifo_head);
                wr_n_d   = 1'b0;
                state_d  = ST_WR_LAT;
            end
        end

        if (mute) begin
            mute_pend_d = 1'b1;
            mute_idx_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cur_q       <= '0;
            mute_pend_q <= 1'b0;
            mute_idx_q  <= '0;
            wr_n_q      <= 1'b1;
            din_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            mute_pend_q <= mute_pend_d;
            mute_idx_q  <= mute_idx_d;
            wr_n_q      <= wr_n_d;
            din_q       <= din_d;
        end
    end

endmodule
